cpu_seq: RTL and testbench
==========================

CPU_SEQ -- requirements
Module: cpu_seq

Interface
REQ-001 Parameter OP_LDR, default 3'b100, opcode of load (memory to register file).
REQ-002 Parameter OP_STR, default 3'b101, opcode of store (register file to memory).
REQ-003 Parameter OP_BNE, default 3'b110, opcode of conditional branch, taken when z==0.
REQ-004 Parameter OP_HALT, default 3'b111, opcode that stops the sequencer.
REQ-005 Parameter MAX_WAIT, default 8, number of MEM cycles allowed without mem_ready before a timeout.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  request to run a program from IDLE or HALT.
REQ-009 inst  input  9  current machine code word; opcode is inst[8:6].
REQ-010 z  input  1  ALU zero flag, valid during EXEC.
REQ-011 mem_ready  input  1  data memory access completes this cycle.
REQ-012 ir_we  output  1  latch inst into the instruction register.
REQ-013 pc_en  output  1  advance PC this cycle.
REQ-014 pc_br  output  1  PC takes the branch target instead of PC+1; valid only with pc_en.
REQ-015 rf_we  output  1  register file write enable.
REQ-016 dm_re  output  1  data memory read request.
REQ-017 dm_we  output  1  data memory write request.
REQ-018 busy  output  1  sequencer is executing a program.
REQ-019 done  output  1  one-cycle pulse on entry to HALT.
REQ-020 err  output  1  sticky memory-timeout flag.
REQ-021 retired  output  16  count of instructions retired.
REQ-022 state  output  3  current state encoding, for debug.

Function
REQ-023 The state encoding SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; encoding 7 SHALL go to IDLE on the next edge.
REQ-024 IDLE: start=1 SHALL move to FETCH and clear retired and err; otherwise the sequencer SHALL stay in IDLE.
REQ-025 FETCH: ir_we=1 for exactly one cycle, then DECODE.
REQ-026 DECODE: op==OP_HALT SHALL go to HALT; all other opcodes SHALL go to EXEC.
REQ-027 EXEC, op in {OP_LDR, OP_STR}: next state MEM, with the wait counter cleared to 0.
REQ-028 EXEC, op==OP_BNE: pc_en=1, pc_br=~z (combinational from z), next state FETCH.
REQ-029 EXEC, any other op: next state WB.
REQ-030 MEM: dm_re=1 for OP_LDR or dm_we=1 for OP_STR, held every cycle until mem_ready=1.
REQ-031 MEM with mem_ready=1: OP_LDR SHALL go to WB; OP_STR SHALL assert pc_en=1 in that cycle and go to FETCH.
REQ-032 MEM with mem_ready=0: the wait counter increments; when it reaches MAX_WAIT, err SHALL be set, the request SHALL drop, and the next state SHALL be HALT.
REQ-033 WB: rf_we=1 and pc_en=1 for one cycle, then FETCH.
REQ-034 HALT: done=1 in the first HALT cycle only; start=1 SHALL go to FETCH and clear retired and err.
REQ-035 retired SHALL increment in every cycle with pc_en=1 and saturate at 16'hFFFF.
REQ-036 busy SHALL be 1 in states FETCH..WB and 0 in IDLE and HALT.
REQ-037 start SHALL be ignored while busy=1.
REQ-038 Outputs other than pc_br SHALL be decoded from the registered state only (Moore); pc_br SHALL be 0 outside EXEC.
REQ-039 At most one of rf_we, dm_we, ir_we SHALL be high in any cycle.
REQ-040 mem_ready outside MEM SHALL be ignored.
REQ-041 Latency per instruction SHALL be: ALU/LDI/LSH 4 cycles; BNE 3 cycles; STR 3+W cycles; LDR 4+W cycles, where W is the number of MEM cycles.

Reset
REQ-042 reset=1 at any edge, including mid-MEM, SHALL force state=IDLE, retired=0, err=0 and the wait counter to 0.
REQ-043 During and in the cycle after reset, all enables, busy and done SHALL be 0; no partial memory write SHALL be held.

Verification
REQ-044 reset, then start pulse, inst op=3'b000 -> ir_we at cycle 1; rf_we=pc_en=1 at cycle 4; retired=1.
REQ-045 OP_STR with mem_ready raised on the 3rd MEM cycle -> dm_we high for 3 cycles; pc_en on that 3rd cycle; rf_we never high.
REQ-046 OP_BNE with z=0 -> pc_en=pc_br=1 in EXEC; with z=1 -> pc_en=1, pc_br=0.
REQ-047 OP_LDR with mem_ready held low -> dm_re low after 8 MEM cycles; err=1; done pulse once; state=6.
REQ-048 reset asserted in the 2nd MEM cycle of OP_STR -> next cycle state=0, dm_we=0, err=0; start pulse in HALT -> FETCH, retired cleared.

Source files
------------

// File: rtl/cpu_seq.sv
// cpu_seq: multi-cycle control sequencer for a small 9-bit CPU.
// Steps FETCH/DECODE/EXEC/MEM/WB and drives IR, PC, RF and DM enables.
module cpu_seq #(
    parameter logic [2:0] OP_LDR   = 3'b100,
    parameter logic [2:0] OP_STR   = 3'b101,
    parameter logic [2:0] OP_BNE   = 3'b110,
    parameter logic [2:0] OP_HALT  = 3'b111,
    parameter int         MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [8:0]  inst,
    input  logic        z,
    input  logic        mem_ready,
    output logic        ir_we,
    output logic        pc_en,
    output logic        pc_br,
    output logic        rf_we,
    output logic        dm_re,
    output logic        dm_we,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] retired,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [WW-1:0] W_LAST = WW'(MAX_WAIT - 1);

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic            err_q, err_d;
    logic [15:0]     ret_q, ret_d;
    logic            done_q, done_d;

    logic            is_ld;
    logic            is_st;
    logic            unused_inst;

    assign is_ld       = (op_q == OP_LDR);
    assign is_st       = (op_q == OP_STR);
    assign unused_inst = ^inst[5:0];

    assign err     = err_q;
    assign retired = ret_q;
    assign state   = state_q;

    // Enables decoded from the registered state; held low while reset is high.
    always_comb begin
        ir_we = 1'b0;
        pc_en = 1'b0;
        pc_br = 1'b0;
        rf_we = 1'b0;
        dm_re = 1'b0;
        dm_we = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    ir_we = 1'b1;
                    busy  = 1'b1;
                end
                S_DECODE: busy = 1'b1;
                S_EXEC: begin
                    busy = 1'b1;
                    if (op_q == OP_BNE) begin
                        pc_en = 1'b1;
                        pc_br = ~z;
                    end
                end
                S_MEM: begin
                    busy  = 1'b1;
                    dm_re = is_ld;
                    dm_we = is_st;
                    pc_en = is_st & mem_ready;
                end
                S_WB: begin
                    busy  = 1'b1;
                    rf_we = 1'b1;
                    pc_en = 1'b1;
                end
                S_HALT:  done = done_q;
                default: ;
            endcase
        end
    end

    // Next-state, wait counter, sticky error and retire counter.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        ret_d   = ret_q;
        if (pc_en && ret_q != 16'hFFFF) begin
            ret_d = ret_q + 16'd1;
        end
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    ret_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_FETCH: begin
                op_d    = inst[8:6];
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = (op_q == OP_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (is_ld || is_st) begin
                    state_d = S_MEM;
                    wcnt_d  = '0;
                end else if (op_q == OP_BNE) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = is_ld ? S_WB : S_FETCH;
                end else if (wcnt_q == W_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_HALT) && (state_q != S_HALT);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            ret_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            ret_q   <= ret_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: directed plus random program runs for cpu_seq,
// checked cycle by cycle against a per-instruction reference model.
module tb_cpu_seq;

    localparam logic [2:0] OP_LDR   = 3'b100;
    localparam logic [2:0] OP_STR   = 3'b101;
    localparam logic [2:0] OP_BNE   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;
    localparam int         MAX_WAIT = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [7:0] F_IR   = 8'h80;
    localparam logic [7:0] F_PC   = 8'h40;
    localparam logic [7:0] F_BR   = 8'h20;
    localparam logic [7:0] F_RF   = 8'h10;
    localparam logic [7:0] F_RE   = 8'h08;
    localparam logic [7:0] F_WE   = 8'h04;
    localparam logic [7:0] F_BUSY = 8'h02;
    localparam logic [7:0] F_DONE = 8'h01;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  inst = '0;
    logic        z = 1'b0;
    logic        mem_ready = 1'b0;
    logic        ir_we, pc_en, pc_br, rf_we, dm_re, dm_we;
    logic        busy, done, err;
    logic [15:0] retired;
    logic [2:0]  state;

    int          total = 0;
    int          bad = 0;
    logic [15:0] m_ret = '0;
    logic        m_err = 1'b0;

    cpu_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .inst      (inst),
        .z         (z),
        .mem_ready (mem_ready),
        .ir_we     (ir_we),
        .pc_en     (pc_en),
        .pc_br     (pc_br),
        .rf_we     (rf_we),
        .dm_re     (dm_re),
        .dm_we     (dm_we),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .retired   (retired),
        .state     (state)
    );

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // One clock cycle: drive inputs, check all outputs at the falling edge.
    task automatic step(input logic [7:0] f, input logic [2:0] st,
                        input logic rst, input logic rdy, input logic zz,
                        input logic stt, input string tag);
        logic [27:0] exp_v;
        logic [27:0] obs_v;
        reset     = rst;
        mem_ready = rdy;
        z         = zz;
        start     = stt;
        @(negedge clk);
        exp_v = {f, m_err, st, m_ret};
        obs_v = {ir_we, pc_en, pc_br, rf_we, dm_re, dm_we, busy, done,
                 err, state, retired};
        total++;
        assert (obs_v === exp_v) else begin
            bad++;
            $error("FAIL %s n=%0d: got %h want %h", tag, total, obs_v, exp_v);
        end
        if ((f & F_PC) != 0 && m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic halt_tail();
        int n;
        step(F_DONE, S_HALT, 1'b0, rb(), rb(), 1'b0, "halt_done");
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            step(8'h00, S_HALT, 1'b0, rb(), rb(), 1'b0, "halt_wait");
        end
        step(8'h00, S_HALT, 1'b0, rb(), rb(), 1'b1, "restart");
        m_ret = '0;
        m_err = 1'b0;
    endtask

    // rdy_at: MEM cycle (1-based) where mem_ready rises, 0 = never.
    // zsel: 0/1 forces z in EXEC, 2 randomizes it.
    task automatic run_inst(input logic [2:0] op, input int rdy_at,
                            input int zsel);
        logic       zz;
        logic       r;
        logic       got;
        logic [7:0] f;
        inst = {op, 6'($urandom)};
        step(F_IR | F_BUSY, S_FETCH, 1'b0, rb(), rb(), rb(), "fetch");
        step(F_BUSY, S_DECODE, 1'b0, rb(), rb(), rb(), "decode");
        if (op == OP_HALT) begin
            halt_tail();
            return;
        end
        zz = (zsel == 2) ? rb() : zsel[0];
        if (op == OP_BNE) begin
            f = F_BUSY | F_PC | (zz ? 8'h00 : F_BR);
            step(f, S_EXEC, 1'b0, rb(), zz, rb(), "bne");
            return;
        end
        step(F_BUSY, S_EXEC, 1'b0, rb(), zz, rb(), "exec");
        if (op == OP_LDR || op == OP_STR) begin
            got = 1'b0;
            for (int i = 1; i <= MAX_WAIT && !got; i++) begin
                r = (i == rdy_at);
                f = F_BUSY | ((op == OP_LDR) ? F_RE : F_WE);
                if (r && op == OP_STR) f = f | F_PC;
                step(f, S_MEM, 1'b0, r, rb(), rb(), "mem");
                got = r;
            end
            if (!got) begin
                m_err = 1'b1;
                halt_tail();
                return;
            end
            if (op == OP_STR) return;
        end
        step(F_RF | F_PC | F_BUSY, S_WB, 1'b0, rb(), rb(), rb(), "wb");
    endtask

    initial begin
        logic [2:0] op;
        int         ra;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step(8'h00, S_IDLE, 1'b1, 1'b1, 1'b1, 1'b1, "in_reset");
        step(8'h00, S_IDLE, 1'b0, 1'b1, rb(), 1'b0, "idle");
        step(8'h00, S_IDLE, 1'b0, rb(), rb(), 1'b1, "go");
        m_ret = '0;
        m_err = 1'b0;

        run_inst(3'b000, 0, 2);
        run_inst(OP_STR, 3, 2);
        run_inst(OP_BNE, 0, 0);
        run_inst(OP_BNE, 0, 1);
        run_inst(OP_LDR, 2, 2);
        run_inst(OP_LDR, 0, 2);
        run_inst(3'b011, 0, 2);
        run_inst(OP_STR, 1, 2);
        run_inst(OP_HALT, 0, 2);

        // Reset in the second MEM cycle of a store.
        inst = {OP_STR, 6'h15};
        step(F_IR | F_BUSY, S_FETCH, 1'b0, rb(), rb(), 1'b0, "r_fetch");
        step(F_BUSY, S_DECODE, 1'b0, rb(), rb(), 1'b0, "r_decode");
        step(F_BUSY, S_EXEC, 1'b0, rb(), rb(), 1'b0, "r_exec");
        step(F_BUSY | F_WE, S_MEM, 1'b0, 1'b0, rb(), 1'b0, "r_mem1");
        step(8'h00, S_MEM, 1'b1, 1'b0, rb(), 1'b0, "r_mem2_rst");
        m_ret = '0;
        m_err = 1'b0;
        step(8'h00, S_IDLE, 1'b0, 1'b1, rb(), 1'b0, "post_rst");
        step(8'h00, S_IDLE, 1'b0, rb(), rb(), 1'b1, "go2");

        for (int n = 0; n < 80; n++) begin
            op = 3'($urandom);
            ra = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, MAX_WAIT);
            run_inst(op, ra, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
